// File: rtl/morph_pkg.sv
// Shared definitions for the streaming morphology blocks.
// ERODE_BORDER_ZERO_EN selects 0 instead of 1 as the value of out-of-image neighbours.
package morph_pkg;

    localparam int MASK_TL = 8;
    localparam int MASK_T  = 7;
    localparam int MASK_TR = 6;
    localparam int MASK_L  = 5;
    localparam int MASK_C  = 4;
    localparam int MASK_R  = 3;
    localparam int MASK_BL = 2;
    localparam int MASK_B  = 1;
    localparam int MASK_BR = 0;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        FLUSH
    } state_t;

`ifdef ERODE_BORDER_ZERO_EN
    localparam logic PAD_VALUE = 1'b0;
`else
    localparam logic PAD_VALUE = 1'b1;
`endif

endpackage

// File: rtl/stream_erode_if.sv
// One-bit pixel stream with valid/ready handshake and an end-of-frame marker.
interface stream_erode_if;
    logic pixel;
    logic valid;
    logic ready;
    logic last;

    modport master (output pixel, valid, last, input ready);
    modport slave  (input pixel, valid, last, output ready);
endinterface

// File: rtl/erode_kernel.sv
// Combinational 3x3 erosion of one window; out-of-image neighbours read as PAD_VALUE.
module erode_kernel
    import morph_pkg::*;
(
    input  logic [8:0] window_i,
    input  logic [8:0] mask_i,
    input  logic       top_i,
    input  logic       bottom_i,
    input  logic       left_i,
    input  logic       right_i,
    output logic       pixel_o
);
    logic [8:0] outside;

    always_comb begin
        outside          = '0;
        outside[MASK_TL] = top_i | left_i;
        outside[MASK_T]  = top_i;
        outside[MASK_TR] = top_i | right_i;
        outside[MASK_L]  = left_i;
        outside[MASK_R]  = right_i;
        outside[MASK_BL] = bottom_i | left_i;
        outside[MASK_B]  = bottom_i;
        outside[MASK_BR] = bottom_i | right_i;
    end

    // An empty mask leaves the AND at its identity, so every pixel becomes 1.
    always_comb begin
        pixel_o = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (mask_i[i]) begin
                pixel_o = pixel_o & (outside[i] ? PAD_VALUE : window_i[i]);
            end
        end
    end
endmodule

// File: rtl/stream_erode.sv
// Streaming 3x3 binary erosion of a Width x Height raster image, one pixel per handshake.
// Build option ERODE_BORDER_ZERO_EN (see morph_pkg) pads the image border with 0 instead of 1.
module stream_erode
    import morph_pkg::*;
#(
    parameter int Width  = 32,
    parameter int Height = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [8:0]            mask_i,
    output logic                  busy_o,
    stream_erode_if.slave         inStream,
    stream_erode_if.master        outStream
);
    localparam int NumPix = Width * Height;
    localparam int IdxW   = $clog2(NumPix) + 1;
    localparam int RowW   = $clog2(Height) + 1;
    localparam int ColW   = $clog2(Width) + 1;
    localparam int SrLen  = 2 * Width + 2;

    localparam logic [IdxW-1:0] FillLastIdx = IdxW'(Width);
    localparam logic [IdxW-1:0] LastIdx     = IdxW'(NumPix - 1);
    localparam logic [RowW-1:0] LastRow     = RowW'(Height - 1);
    localparam logic [ColW-1:0] LastCol     = ColW'(Width - 1);

    state_t            state_q, state_d;
    logic [IdxW-1:0]   inIdx_q, inIdx_d;
    logic [RowW-1:0]   outRow_q, outRow_d;
    logic [ColW-1:0]   outCol_q, outCol_d;
    logic [SrLen-1:0]  sr_q, sr_d;
    logic [8:0]        mask_q, mask_d;
    logic              busy_q, busy_d;
    logic              outPixel_q, outPixel_d;
    logic              outValid_q, outValid_d;
    logic              outLast_q, outLast_d;

    logic              outFree;
    logic              inReady;
    logic              accept;
    logic              newPixel;
    logic              loadOut;
    logic              kernelPixel;
    logic [8:0]        window;

    assign outFree = !outValid_q || outStream.ready;
    assign inReady = (state_q != FLUSH) && outFree;
    assign accept  = inStream.valid && inReady;

    // sr_q[0] is the newest stored pixel; the incoming pixel completes the bottom-right corner.
    always_comb begin
        newPixel         = (state_q == FLUSH) ? PAD_VALUE : inStream.pixel;
        window           = '0;
        window[MASK_TL]  = sr_q[2*Width+1];
        window[MASK_T]   = sr_q[2*Width];
        window[MASK_TR]  = sr_q[2*Width-1];
        window[MASK_L]   = sr_q[Width+1];
        window[MASK_C]   = sr_q[Width];
        window[MASK_R]   = sr_q[Width-1];
        window[MASK_BL]  = sr_q[1];
        window[MASK_B]   = sr_q[0];
        window[MASK_BR]  = newPixel;
    end

    erode_kernel u_kernel (
        .window_i (window),
        .mask_i   (mask_q),
        .top_i    (outRow_q == '0),
        .bottom_i (outRow_q == LastRow),
        .left_i   (outCol_q == '0),
        .right_i  (outCol_q == LastCol),
        .pixel_o  (kernelPixel)
    );

    always_comb begin
        state_d    = state_q;
        inIdx_d    = inIdx_q;
        outRow_d   = outRow_q;
        outCol_d   = outCol_q;
        sr_d       = sr_q;
        mask_d     = mask_q;
        busy_d     = busy_q;
        outPixel_d = outPixel_q;
        outValid_d = outValid_q;
        outLast_d  = outLast_q;
        loadOut    = 1'b0;

        if (outValid_q && outStream.ready) begin
            outValid_d = 1'b0;
            outLast_d  = 1'b0;
        end

        case (state_q)
            FILL: begin
                if (accept) begin
                    sr_d    = {sr_q[SrLen-2:0], newPixel};
                    inIdx_d = inIdx_q + IdxW'(1);
                    if (inIdx_q == '0) begin
                        mask_d = mask_i;
                        busy_d = 1'b1;
                    end
                    if (inIdx_q == FillLastIdx) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    sr_d    = {sr_q[SrLen-2:0], newPixel};
                    loadOut = 1'b1;
                    if (inIdx_q == LastIdx) begin
                        inIdx_d = '0;
                        state_d = FLUSH;
                    end else begin
                        inIdx_d = inIdx_q + IdxW'(1);
                    end
                end
            end
            FLUSH: begin
                // A free slot while the last pixel is held means that pixel is leaving now.
                if (outFree) begin
                    if (outValid_q && outLast_q) begin
                        state_d = FILL;
                        busy_d  = 1'b0;
                    end else begin
                        sr_d    = {sr_q[SrLen-2:0], newPixel};
                        loadOut = 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase

        if (loadOut) begin
            outPixel_d = kernelPixel;
            outValid_d = 1'b1;
            outLast_d  = (outRow_q == LastRow) && (outCol_q == LastCol);
            if (outCol_q == LastCol) begin
                outCol_d = '0;
                outRow_d = (outRow_q == LastRow) ? '0 : outRow_q + RowW'(1);
            end else begin
                outCol_d = outCol_q + ColW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            inIdx_q    <= '0;
            outRow_q   <= '0;
            outCol_q   <= '0;
            sr_q       <= '0;
            mask_q     <= '0;
            busy_q     <= 1'b0;
            outPixel_q <= 1'b0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inIdx_q    <= inIdx_d;
            outRow_q   <= outRow_d;
            outCol_q   <= outCol_d;
            sr_q       <= sr_d;
            mask_q     <= mask_d;
            busy_q     <= busy_d;
            outPixel_q <= outPixel_d;
            outValid_q <= outValid_d;
            outLast_q  <= outLast_d;
        end
    end

    assign inStream.ready  = inReady;
    assign outStream.pixel = outPixel_q;
    assign outStream.valid = outValid_q;
    assign outStream.last  = outLast_q;
    assign busy_o          = busy_q;
endmodule

// File: tb/tb_stream_erode.sv
// Directed bench for stream_erode on a 4x4 image; bit r*4+c of each image holds pixel (r,c).
// Expected images are hand-computed for the default and the ERODE_BORDER_ZERO_EN build.
module tb_stream_erode;
    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

`ifdef ERODE_BORDER_ZERO_EN
    localparam logic [15:0] AllOnesExp = 16'h0660;
    localparam logic [15:0] HoleExp    = 16'h0000;
`else
    localparam logic [15:0] AllOnesExp = 16'hFFFF;
    localparam logic [15:0] HoleExp    = 16'hF888;
`endif
    localparam logic [15:0] HoleImg = 16'hFFDF;
    localparam logic [15:0] RandImg = 16'hA5C3;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] maskReg;
    logic       busy;
    int         testsRun = 0;
    int         testsFailed = 0;

    stream_erode_if inIf ();
    stream_erode_if outIf ();

    stream_erode #(.Width(W), .Height(H)) dut (
        .clk       (clk),
        .rst       (rst),
        .mask_i    (maskReg),
        .busy_o    (busy),
        .inStream  (inIf),
        .outStream (outIf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Streams one frame in and collects it out; the mask input is scrambled after the first pixel.
    task automatic applyStimulus(input string tag, input logic [8:0] m, input logic [15:0] img,
                                 input bit stall, input logic [15:0] expImg);
        int         inCount = 0;
        int         outCount = 0;
        int         cyc = 0;
        int         acceptsAtFirst = -1;
        logic [15:0] got = '0;
        bit         holding = 1'b0;
        logic       heldPixel = 1'b0;
        logic       heldLast = 1'b0;
        bit         inAcc;
        bit         outAcc;

        while (outCount < N && cyc < 2000) begin
            @(negedge clk);
            inIf.valid   = (inCount < N);
            inIf.pixel   = (inCount < N) ? img[inCount] : 1'b0;
            maskReg      = (inCount == 0) ? m : 9'h000;
            outIf.ready  = stall ? (cyc % 3 == 0) : 1'b1;
            #1;
            if (holding) begin
                checkOutput({tag, " held valid"}, 32'(outIf.valid), 32'd1);
                checkOutput({tag, " held pixel"}, 32'(outIf.pixel), 32'(heldPixel));
                checkOutput({tag, " held last"}, 32'(outIf.last), 32'(heldLast));
            end
            if (outIf.valid && !outIf.ready) begin
                checkOutput({tag, " in_ready stalled"}, 32'(inIf.ready), 32'd0);
            end
            if (outIf.valid && acceptsAtFirst < 0) begin
                acceptsAtFirst = inCount;
                checkOutput({tag, " busy in frame"}, 32'(busy), 32'd1);
            end
            inAcc  = inIf.valid && inIf.ready;
            outAcc = outIf.valid && outIf.ready;
            if (outAcc) begin
                got[outCount] = outIf.pixel;
                checkOutput({tag, " out_last"}, 32'(outIf.last), 32'(outCount == N - 1));
                outCount++;
            end
            holding   = outIf.valid && !outIf.ready;
            heldPixel = outIf.pixel;
            heldLast  = outIf.last;
            if (inAcc) inCount++;
            cyc++;
        end

        checkOutput({tag, " output count"}, 32'(outCount), 32'(N));
        checkOutput({tag, " image"}, 32'(got), 32'(expImg));
        // Output (0,0) is loaded by the acceptance of input index W+1, i.e. after W+2 pixels.
        checkOutput({tag, " latency"}, 32'(acceptsAtFirst), 32'(W + 2));

        @(negedge clk);
        inIf.valid  = 1'b0;
        outIf.ready = 1'b1;
        #1;
        checkOutput({tag, " busy after"}, 32'(busy), 32'd0);
        checkOutput({tag, " in_ready after"}, 32'(inIf.ready), 32'd1);
        checkOutput({tag, " out_valid after"}, 32'(outIf.valid), 32'd0);
    endtask

    task automatic applyMidReset();
        int acc = 0;
        int cyc = 0;
        outIf.ready = 1'b1;
        while (acc < 8 && cyc < 100) begin
            @(negedge clk);
            inIf.valid  = 1'b1;
            inIf.pixel  = 1'b1;
            maskReg     = 9'h1FF;
            #1;
            if (inIf.valid && inIf.ready) acc++;
            cyc++;
        end
        checkOutput("midReset accepts", 32'(acc), 32'd8);
        @(negedge clk);
        inIf.valid = 1'b0;
        #1;
        checkOutput("midReset busy before", 32'(busy), 32'd1);
        checkOutput("midReset valid before", 32'(outIf.valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("midReset out_valid", 32'(outIf.valid), 32'd0);
        checkOutput("midReset busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("midReset in_ready", 32'(inIf.ready), 32'd1);
    endtask

    initial begin
        rst         = 1'b1;
        maskReg     = 9'h000;
        inIf.valid  = 1'b0;
        inIf.pixel  = 1'b0;
        inIf.last   = 1'b0;
        outIf.ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset out_valid", 32'(outIf.valid), 32'd0);
        checkOutput("reset out_pixel", 32'(outIf.pixel), 32'd0);
        checkOutput("reset out_last", 32'(outIf.last), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("reset in_ready", 32'(inIf.ready), 32'd1);

        applyStimulus("allOnes", 9'h1FF, 16'hFFFF, 1'b0, AllOnesExp);
        applyStimulus("hole", 9'h1FF, HoleImg, 1'b0, HoleExp);
        applyStimulus("centre", 9'h010, RandImg, 1'b0, RandImg);
        applyStimulus("stall", 9'h1FF, 16'hFFFF, 1'b1, AllOnesExp);
        applyMidReset();
        applyStimulus("afterReset", 9'h1FF, 16'hFFFF, 1'b0, AllOnesExp);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/stream_erode.md
Name: stream_erode

Overview:
- Streaming 3x3 binary erosion, the AND-dual of the combinational dilate unit.
- Accepts a Width x Height binary image one pixel per handshake, in raster order (row 0 first, column 0 first in each row).
- Emits the eroded image in the same order, through line buffers and a valid/ready output register.
- Sits between a pixel source (sensor or frame reader) and downstream morphology stages; paired with dilate, it builds opening/closing pipelines.

Parameters:
- Width, 32, image columns (>=2)
- Height, 32, image rows (>=2)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- mask  in  9  structuring element; [8]=top-left, [7]=top, [6]=top-right, [5]=left, [4]=centre, [3]=right, [2]=bottom-left, [1]=bottom, [0]=bottom-right
- in_pixel  in  1  input pixel
- in_valid  in  1  input pixel valid
- in_ready  out  1  block accepts in_pixel this cycle
- out_pixel  out  1  eroded pixel
- out_valid  out  1  out_pixel valid
- out_ready  in  1  downstream accepts out_pixel
- out_last  out  1  marks pixel (Height-1, Width-1) of the output frame
- busy  out  1  high from first accepted pixel until the last output pixel is transferred

Behaviour:
- Reset: out_pixel=0, out_valid=0, out_last=0, busy=0, counters=0, line buffers=0, state=FILL. in_ready=1 in the cycle after reset.
- Transfers: input on in_valid&in_ready; output on out_valid&out_ready.
- in_ready = (state!=FLUSH) && (!out_valid || out_ready). This is combinational from out_ready.
- mask is latched on the first accepted pixel of each frame. Mask changes mid-frame are ignored until the next frame.
- Window storage: a shift register of 2*Width+2 bits plus the incoming pixel gives rows l-1, l and l+1 around output pixel (l,c).
- Output rule: out(l,c) = AND over all set mask bits of the corresponding neighbour. Neighbours outside the image read as 1. An all-zero mask yields 1 for every pixel.
- Latency: output (l,c) is produced on acceptance of input index l*Width+c+Width+1.
- States:
  - FILL: accept the first Width+1 pixels and produce no output. Go to RUN after the (Width+1)th acceptance.
  - RUN: each accepted pixel loads one output pixel into the output register. Go to FLUSH after input pixel Width*Height-1 is accepted.
  - FLUSH: in_ready=0. Generate the remaining Width+1 outputs using the bottom padding value, one per free output slot. Return to FILL after the output with out_last is transferred.
- Column wrap:
  - The left neighbour of column 0 and the right neighbour of column Width-1 are padding, never the adjacent row's pixel.
  - The top row uses padding for row -1; the bottom row uses padding for row Height.
- Backpressure: while out_valid && !out_ready, out_pixel, out_valid and out_last hold stable and no input is accepted.
- Mid-frame reset: the frame is discarded with no partial output, and the block returns to the reset state.
- Counters: the input index runs 0..Width*Height-1 and the output row/column counters wrap at Width/Height. Size counters with $clog2 of the maximum count, plus 1 bit.
- Back-to-back frames: a new frame is accepted only after FLUSH completes.

Optional Feature:
- Macro ERODE_BORDER_ZERO_EN.
- Defined: out-of-image neighbours read as 0. Any pixel whose set mask bits reach outside the image outputs 0.
- Undefined: out-of-image neighbours read as 1, as specified above.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package morph_pkg holds:
  - mask bit index constants (MASK_TL=8 ... MASK_BR=0)
  - state enum {FILL, RUN, FLUSH}
  - a padding-value constant selected by ERODE_BORDER_ZERO_EN.
- One sub-module, erode_kernel: combinational 9-bit window + 9-bit mask + 4 edge flags (top/bottom/left/right) -> 1 output bit.
- Counters, shift register and FSM stay in stream_erode.

Test Plan:
- Width=Height=4, mask=9'h1FF, all-ones image, out_ready=1 -> 16 ones; out_last on the 16th; first output 5 accepts after start.
- 4x4, mask=9'h1FF, single 0 at (1,1) -> zeros exactly at (0,0..2), (1,0..2), (2,0..2); all others 1.
- 4x4, mask=9'h010 (centre only), pseudo-random image -> output equals input bit-for-bit.
- 4x4, mask=9'h1FF, all-ones image, out_ready toggled 1 cycle on / 2 off -> still 16 ones. out_pixel stable while stalled; in_ready=0 whenever out_valid&&!out_ready.
- 4x4, mask=9'h1FF, rst after 8 input pixels -> out_valid=0 and busy=0 next cycle. A fresh all-ones frame then yields 16 ones.
- ERODE_BORDER_ZERO_EN defined, 4x4 all-ones, mask=9'h1FF -> only (1,1), (1,2), (2,1), (2,2) are 1.
